memory_access: RTL and testbench

Memory stage of the MIPS/DLX pipeline, directly downstream of `execution`. It latches the execution results into an EX/MEM register and runs a load/store transaction on the data-memory port with a req/ack handshake, stalling the pipeline while the access is outstanding. It then delivers the MEM/WB register to write-back. The EX/MEM values are also exported for the forwarding muxes of `execution`.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/load_store_align.sv | 45 ++++
 rtl/memory_access.sv | 154 +++++++++++++++
 tb/tb_memory_access.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage:
// control-bit indices, size codes and FSM states.
package mem_stage_pkg;

  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int SIZE_LO   = 2;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int REG_WRITE  = 0;
  localparam int MEM_TO_REG = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// Lane alignment for data memory: byte enables,
// store-data replication, load extraction with sign extension.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane; size 11 falls back to word.
  always_comb begin
    be_o      = 4'b1111;
    st_data_o = st_data_i;
    ld_data_o = rd_data_i;
    byte_sel  = rd_data_i[8*lane_i +: 8];
    half_sel  = lane_i[1] ? rd_data_i[31:16]
                          : rd_data_i[15:0];
    unique case (size_i)
      SZ_HALF: begin
        be_o      = lane_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = {{16{half_sel[15]}}, half_sel};
      end
      SZ_BYTE: begin
        be_o      = 4'b0001 << lane_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      end
      default: begin
        be_o      = 4'b1111;
        st_data_o = st_data_i;
        ld_data_o = rd_data_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Pipeline memory stage: EX/MEM and MEM/WB registers,
// req/ack data-memory FSM and saturating stall counter.
module memory_access
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             ex_wb_control,
  input  logic [3:0]             ex_mem_control,
  input  logic [31:0]            ex_alu_out,
  input  logic [31:0]            ex_data_write,
  input  logic [4:0]             ex_wb_register,
  output logic [31:0]            mem_alu_out,
  output logic [4:0]             mem_wb_register,
  output logic                   mem_reg_write,
  output logic                   mem_stall,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ADDR_W-1:0]      dmem_addr,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_be,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_ack,
  output logic [1:0]             wb_control,
  output logic [31:0]            wb_read_data,
  output logic [31:0]            wb_alu_out,
  output logic [4:0]             wb_register,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [1:0]  wbc_q;
  logic [3:0]  memc_q;
  logic [31:0] alu_q;
  logic [31:0] sd_q;
  logic [4:0]  rd_q;

  state_e state_q, state_d;
  logic   req, stall;

  logic [1:0]  mwb_ctrl_q;
  logic [31:0] mwb_rdata_q;
  logic [31:0] mwb_alu_q;
  logic [4:0]  mwb_reg_q;

  logic [STALL_CNT_W-1:0] cnt_q;

  logic [3:0]  be_raw;
  logic [31:0] ld_data;
  logic        is_load;
  logic        ex_is_mem;

  assign ex_is_mem = ex_mem_control[MEM_READ]
                   | ex_mem_control[MEM_WRITE];
  // Read+write together is treated as a store.
  assign is_load = memc_q[MEM_READ] & ~memc_q[MEM_WRITE];

  load_store_align u_align (
    .size_i    (memc_q[SIZE_LO+1:SIZE_LO]),
    .lane_i    (alu_q[1:0]),
    .st_data_i (sd_q),
    .rd_data_i (dmem_rdata),
    .be_o      (be_raw),
    .st_data_o (dmem_wdata),
    .ld_data_o (ld_data)
  );

  // EX/MEM register: capture unless the stage is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbc_q  <= '0;
      memc_q <= '0;
      alu_q  <= '0;
      sd_q   <= '0;
      rd_q   <= '0;
    end else if (!stall) begin
      wbc_q  <= ex_wb_control;
      memc_q <= ex_mem_control;
      alu_q  <= ex_alu_out;
      sd_q   <= ex_data_write;
      rd_q   <= ex_wb_register;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; ack edge may chain straight into a new op.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_is_mem) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        req   = 1'b1;
        stall = ~dmem_ack;
        if (dmem_ack)
          state_d = ex_is_mem ? ST_BUSY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB register: bubble while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mwb_ctrl_q  <= '0;
      mwb_rdata_q <= '0;
      mwb_alu_q   <= '0;
      mwb_reg_q   <= '0;
    end else if (stall) begin
      mwb_ctrl_q  <= '0;
      mwb_rdata_q <= '0;
      mwb_alu_q   <= '0;
      mwb_reg_q   <= '0;
    end else begin
      mwb_ctrl_q  <= wbc_q;
      mwb_rdata_q <= is_load ? ld_data : 32'h0;
      mwb_alu_q   <= alu_q;
      mwb_reg_q   <= rd_q;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (stall && (cnt_q != '1))
      cnt_q <= cnt_q + STALL_CNT_W'(1);
  end

  assign mem_alu_out     = alu_q;
  assign mem_wb_register = rd_q;
  assign mem_reg_write   = wbc_q[REG_WRITE];
  assign mem_stall       = stall;
  assign dmem_req        = req;
  assign dmem_we         = memc_q[MEM_WRITE];
  assign dmem_addr       = alu_q[ADDR_W+1:2];
  assign dmem_be         = req ? be_raw : 4'b0000;
  assign wb_control      = mwb_ctrl_q;
  assign wb_read_data    = mwb_rdata_q;
  assign wb_alu_out      = mwb_alu_q;
  assign wb_register     = mwb_reg_q;
  assign stall_cycles    = cnt_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access.
// Inputs change and outputs are checked just after negedge.
module tb_memory_access;

  logic        clk;
  logic        reset;
  logic [1:0]  ex_wb_control;
  logic [3:0]  ex_mem_control;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_data_write;
  logic [4:0]  ex_wb_register;
  logic [31:0] mem_alu_out;
  logic [4:0]  mem_wb_register;
  logic        mem_reg_write;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [1:0]  wb_control;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_out;
  logic [4:0]  wb_register;
  logic [15:0] stall_cycles;

  int total;
  int bad;

  memory_access #(.ADDR_W(10), .STALL_CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_wb_control   (ex_wb_control),
    .ex_mem_control  (ex_mem_control),
    .ex_alu_out      (ex_alu_out),
    .ex_data_write   (ex_data_write),
    .ex_wb_register  (ex_wb_register),
    .mem_alu_out     (mem_alu_out),
    .mem_wb_register (mem_wb_register),
    .mem_reg_write   (mem_reg_write),
    .mem_stall       (mem_stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_be         (dmem_be),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .wb_control      (wb_control),
    .wb_read_data    (wb_read_data),
    .wb_alu_out      (wb_alu_out),
    .wb_register     (wb_register),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_nop();
    ex_wb_control  = 2'b00;
    ex_mem_control = 4'b0000;
    ex_alu_out     = 32'h0;
    ex_data_write  = 32'h0;
    ex_wb_register = 5'd0;
  endtask

  task automatic drive_op(input logic [1:0] wbc,
                          input logic [3:0] memc,
                          input logic [31:0] alu,
                          input logic [31:0] sd,
                          input logic [4:0] rd);
    ex_wb_control  = wbc;
    ex_mem_control = memc;
    ex_alu_out     = alu;
    ex_data_write  = sd;
    ex_wb_register = rd;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (dmem_req !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%b exp=0", dmem_req);
    end
    total++;
    if (mem_stall !== 1'b0) begin
      bad++; $display("FAIL rst_stall got=%b exp=0", mem_stall);
    end
    total++;
    if (wb_control !== 2'b00) begin
      bad++; $display("FAIL rst_wbc got=%b exp=00", wb_control);
    end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cycles);
    end
    total++;
    if (mem_alu_out !== 32'h0) begin
      bad++; $display("FAIL rst_alu got=%h exp=0", mem_alu_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu_op();
    drive_op(2'b01, 4'b0000, 32'h1234, 32'h0, 5'd7);
    @(negedge clk);
    drive_nop();
    #1;
    total++;
    if (mem_alu_out !== 32'h1234) begin
      bad++; $display("FAIL alu_exmem got=%h exp=1234", mem_alu_out);
    end
    total++;
    if (mem_reg_write !== 1'b1 || mem_wb_register !== 5'd7) begin
      bad++;
      $display("FAIL alu_fwd got=%b/%0d exp=1/7",
               mem_reg_write, mem_wb_register);
    end
    total++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL alu_nostall got=%b/%b exp=0/0",
               mem_stall, dmem_req);
    end
    @(negedge clk);
    #1;
    total++;
    if (wb_alu_out !== 32'h1234) begin
      bad++; $display("FAIL alu_wb got=%h exp=1234", wb_alu_out);
    end
    total++;
    if (wb_register !== 5'd7 || wb_control !== 2'b01) begin
      bad++;
      $display("FAIL alu_wbreg got=%0d/%b exp=7/01",
               wb_register, wb_control);
    end
    total++;
    if (wb_read_data !== 32'h0 || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL alu_rd got=%h/%b exp=0/0",
               wb_read_data, mem_stall);
    end
  endtask

  task automatic test_word_store();
    drive_op(2'b00, 4'b0010, 32'h40, 32'hDEADBEEF, 5'd0);
    @(negedge clk);
    drive_nop();
    dmem_ack = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      bad++;
      $display("FAIL ws_req got=%b/%b exp=1/1", dmem_req, dmem_we);
    end
    total++;
    if (dmem_addr !== 10'h10) begin
      bad++; $display("FAIL ws_addr got=%h exp=010", dmem_addr);
    end
    total++;
    if (dmem_be !== 4'b1111) begin
      bad++; $display("FAIL ws_be got=%b exp=1111", dmem_be);
    end
    total++;
    if (dmem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ws_wdata got=%h exp=deadbeef", dmem_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_stall !== 1'b1) begin
        bad++; $display("FAIL ws_stall%0d got=%b exp=1", i, mem_stall);
      end
      total++;
      if (dmem_addr !== 10'h10 || dmem_req !== 1'b1) begin
        bad++;
        $display("FAIL ws_hold%0d got=%h/%b exp=010/1",
                 i, dmem_addr, dmem_req);
      end
      if (i > 0) begin
        total++;
        if (wb_control !== 2'b00) begin
          bad++; $display("FAIL ws_bubble%0d got=%b exp=00", i, wb_control);
        end
      end
      @(negedge clk);
      #1;
    end
    dmem_ack = 1'b1;
    #1;
    total++;
    if (stall_cycles !== 16'd3) begin
      bad++; $display("FAIL ws_cnt got=%0d exp=3", stall_cycles);
    end
    total++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL ws_ack got=%b/%b exp=0/1", mem_stall, dmem_req);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_cycles !== 16'd3) begin
      bad++;
      $display("FAIL ws_done got=%b/%0d exp=0/3", dmem_req, stall_cycles);
    end
  endtask

  task automatic test_byte_load();
    drive_op(2'b11, 4'b1001, 32'h43, 32'h0, 5'd9);
    @(negedge clk);
    drive_nop();
    dmem_rdata = 32'h80FF_0000;
    dmem_ack   = 1'b1;
    #1;
    total++;
    if (dmem_be !== 4'b1000 || dmem_we !== 1'b0) begin
      bad++;
      $display("FAIL bl_be got=%b/%b exp=1000/0", dmem_be, dmem_we);
    end
    total++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL bl_req got=%b/%b exp=0/1", mem_stall, dmem_req);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    total++;
    if (wb_read_data !== 32'hFFFFFF80) begin
      bad++; $display("FAIL bl_data got=%h exp=ffffff80", wb_read_data);
    end
    total++;
    if (wb_control !== 2'b11 || wb_register !== 5'd9) begin
      bad++;
      $display("FAIL bl_wb got=%b/%0d exp=11/9", wb_control, wb_register);
    end
    total++;
    if (stall_cycles !== 16'd3 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL bl_cnt got=%0d/%b exp=3/0", stall_cycles, dmem_req);
    end
  endtask

  task automatic test_half_store();
    drive_op(2'b00, 4'b0110, 32'h22, 32'h0000ABCD, 5'd0);
    @(negedge clk);
    drive_nop();
    dmem_ack = 1'b1;
    #1;
    total++;
    if (dmem_be !== 4'b1100) begin
      bad++; $display("FAIL hs_be got=%b exp=1100", dmem_be);
    end
    total++;
    if (dmem_wdata !== 32'hABCDABCD) begin
      bad++; $display("FAIL hs_wdata got=%h exp=abcdabcd", dmem_wdata);
    end
    total++;
    if (dmem_addr !== 10'h008 || dmem_we !== 1'b1) begin
      bad++;
      $display("FAIL hs_addr got=%h/%b exp=008/1", dmem_addr, dmem_we);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || dmem_be !== 4'b0000) begin
      bad++;
      $display("FAIL hs_idle got=%b/%b exp=0/0000", dmem_req, dmem_be);
    end
  endtask

  task automatic test_back_to_back();
    drive_op(2'b11, 4'b0001, 32'h100, 32'h0, 5'd3);
    @(negedge clk);
    drive_op(2'b11, 4'b0001, 32'h104, 32'h0, 5'd4);
    dmem_ack = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b1 || dmem_addr !== 10'h040) begin
      bad++;
      $display("FAIL bb_first got=%b/%h exp=1/040", dmem_req, dmem_addr);
    end
    total++;
    if (mem_stall !== 1'b1) begin
      bad++; $display("FAIL bb_stall1 got=%b exp=1", mem_stall);
    end
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11112222;
    #1;
    total++;
    if (dmem_req !== 1'b1 || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL bb_ack1 got=%b/%b exp=1/0", dmem_req, mem_stall);
    end
    @(negedge clk);
    drive_nop();
    dmem_ack = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b1 || dmem_addr !== 10'h041) begin
      bad++;
      $display("FAIL bb_second got=%b/%h exp=1/041", dmem_req, dmem_addr);
    end
    total++;
    if (wb_read_data !== 32'h11112222 || wb_register !== 5'd3) begin
      bad++;
      $display("FAIL bb_wb1 got=%h/%0d exp=11112222/3",
               wb_read_data, wb_register);
    end
    total++;
    if (wb_control !== 2'b11) begin
      bad++; $display("FAIL bb_wbc1 got=%b exp=11", wb_control);
    end
    @(negedge clk);
    #1;
    total++;
    if (wb_control !== 2'b00 || mem_stall !== 1'b1) begin
      bad++;
      $display("FAIL bb_bubble got=%b/%b exp=00/1", wb_control, mem_stall);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h33334444;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    total++;
    if (wb_read_data !== 32'h33334444 || wb_register !== 5'd4) begin
      bad++;
      $display("FAIL bb_wb2 got=%h/%0d exp=33334444/4",
               wb_read_data, wb_register);
    end
    total++;
    if (dmem_req !== 1'b0 || stall_cycles !== 16'd5) begin
      bad++;
      $display("FAIL bb_end got=%b/%0d exp=0/5", dmem_req, stall_cycles);
    end
  endtask

  task automatic test_reset_busy();
    drive_op(2'b11, 4'b0001, 32'h80, 32'h0, 5'd6);
    @(negedge clk);
    drive_nop();
    dmem_ack = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++; $display("FAIL rb_busy got=%b exp=1", dmem_req);
    end
    reset = 1'b1;
    #1;
    total++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL rb_async got=%b/%b exp=0/0", dmem_req, mem_stall);
    end
    total++;
    if (dmem_addr !== 10'h0 || mem_alu_out !== 32'h0) begin
      bad++;
      $display("FAIL rb_clear got=%h/%h exp=0/0", dmem_addr, mem_alu_out);
    end
    total++;
    if (stall_cycles !== 16'd0 || wb_control !== 2'b00) begin
      bad++;
      $display("FAIL rb_cnt got=%0d/%b exp=0/00", stall_cycles, wb_control);
    end
    @(negedge clk);
    reset    = 1'b0;
    dmem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (wb_control !== 2'b00 || dmem_req !== 1'b0) begin
        bad++;
        $display("FAIL rb_nowb%0d got=%b/%b exp=00/0",
                 i, wb_control, dmem_req);
      end
    end
    dmem_ack = 1'b0;
    drive_op(2'b01, 4'b0000, 32'hBEEF, 32'h0, 5'd2);
    @(negedge clk);
    drive_nop();
    @(negedge clk);
    #1;
    total++;
    if (wb_alu_out !== 32'hBEEF || wb_register !== 5'd2) begin
      bad++;
      $display("FAIL rb_next got=%h/%0d exp=beef/2",
               wb_alu_out, wb_register);
    end
    total++;
    if (wb_control !== 2'b01) begin
      bad++; $display("FAIL rb_nextc got=%b exp=01", wb_control);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive_nop();
    test_reset();
    test_alu_op();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_back_to_back();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
